// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and window size shared by the GPIO controller files
package gpio_pkg;
  localparam int GPIO_WIN_BITS = 3;
  typedef enum logic [GPIO_WIN_BITS-1:0] {
    GPIO_OUT     = 3'd0,
    GPIO_OE      = 3'd1,
    GPIO_IN      = 3'd2,
    GPIO_RISE_EN = 3'd3,
    GPIO_FALL_EN = 3'd4,
    GPIO_EVENT   = 3'd5,
    GPIO_SET     = 3'd6,
    GPIO_CLR     = 3'd7
  } gpio_reg_e;
endpackage

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: j1 io bus bundle between the CPU (master) and an io peripheral (slave)
// io_addr/io_wdata/io_wr/io_rd driven by the master, io_rdata returned by the slave
interface gpio_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] io_addr;
  logic [DATA_WIDTH-1:0] io_wdata;
  logic                  io_wr;
  logic                  io_rd;
  logic [DATA_WIDTH-1:0] io_rdata;
  modport master (output io_addr, io_wdata, io_wr, io_rd, input io_rdata);
  modport slave (input io_addr, io_wdata, io_wr, io_rd, output io_rdata);
endinterface

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-pin filter, q follows d only after d has differed from q for CYCLES consecutive clocks
// clk/rst: clock and async active-high reset; d: synchronised pin; q: filtered pin
module gpio_debounce #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d == q) cnt <= '0;
    else if (cnt == CW'(CYCLES - 1)) begin
      q   <= d;
      cnt <= '0;
    end else cnt <= cnt + CW'(1);
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: WIDTH-pin GPIO on the j1 io bus with synchronisers, edge events (w1c), SET/CLR and irq
// clk/rst: clock and async active-high reset; io: io bus slave (8-word window at BASE_ADDR)
// gpio_in: raw pads; gpio_out/gpio_oe: output data and drive enable; irq: OR of EVENT bits
// GPIO_DEBOUNCE_EN: when defined, each pin passes through a DEBOUNCE_CYCLES filter after the synchroniser
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int                    WIDTH           = 8,
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 16'h0040,
  parameter int                    DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  gpio_ctrl_if.slave       io,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  logic [WIDTH-1:0] sync1, sync2, filt, prev, rise_en, fall_en, event_r, wd, w1c, rdata;
  logic hit, wr, unused_wdata;
  gpio_reg_e off;
  if (WIDTH < 1 || WIDTH > DATA_WIDTH) begin : g_bad_width
    $error("gpio_ctrl: WIDTH must be 1..DATA_WIDTH");
  end
  if (BASE_ADDR[GPIO_WIN_BITS-1:0] != '0) begin : g_bad_base
    $error("gpio_ctrl: BASE_ADDR must be 8-word aligned");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("gpio_ctrl: DEBOUNCE_CYCLES must be >= 2");
  end
  assign hit = io.io_addr[ADDR_WIDTH-1:GPIO_WIN_BITS] == BASE_ADDR[ADDR_WIDTH-1:GPIO_WIN_BITS];
  assign off = gpio_reg_e'(io.io_addr[GPIO_WIN_BITS-1:0]);
  assign wr = io.io_wr && hit;
  assign wd = io.io_wdata[WIDTH-1:0];
  assign unused_wdata = ^io.io_wdata;
  assign w1c = (wr && off == GPIO_EVENT) ? wd : '0;
  assign irq = |event_r;
`ifdef GPIO_DEBOUNCE_EN
  for (genvar p = 0; p < WIDTH; p++) begin : g_db
    gpio_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .rst(rst),
      .d  (sync2[p]),
      .q  (filt[p])
    );
  end
`else
  assign filt = sync2;
`endif
  // a fresh edge in the same cycle as its W1C is ORed in after the clear, so it is kept
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= '0;
      event_r  <= '0;
      gpio_out <= '0;
      gpio_oe  <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else begin
      sync1   <= gpio_in;
      sync2   <= sync1;
      prev    <= filt;
      event_r <= (event_r & ~w1c) | (filt & ~prev & rise_en) | (~filt & prev & fall_en);
      if (wr)
        case (off)
          GPIO_OUT:     gpio_out <= wd;
          GPIO_OE:      gpio_oe  <= wd;
          GPIO_RISE_EN: rise_en  <= wd;
          GPIO_FALL_EN: fall_en  <= wd;
          GPIO_SET:     gpio_out <= gpio_out | wd;
          GPIO_CLR:     gpio_out <= gpio_out & ~wd;
          default:      ;
        endcase
    end
  always_comb begin
    rdata = '0;
    case (off)
      GPIO_OUT:     rdata = gpio_out;
      GPIO_OE:      rdata = gpio_oe;
      GPIO_IN:      rdata = filt;
      GPIO_RISE_EN: rdata = rise_en;
      GPIO_FALL_EN: rdata = fall_en;
      GPIO_EVENT:   rdata = event_r;
      default:      rdata = '0;
    endcase
  end
  assign io.io_rdata = (io.io_rd && hit) ? DATA_WIDTH'(rdata) : '0;
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: self-checking bench for gpio_ctrl (register table, edge/event sequences, async reset)
module tb_gpio_ctrl;
  localparam int DB = 4;
  localparam logic [15:0] B = 16'h0040;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] gpio_in = '0;
  logic [7:0] gpio_out, gpio_oe;
  logic irq;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;
  sb_t sb[$];
  typedef struct {
    logic        do_wr;
    logic [15:0] wa;
    logic [15:0] wd;
    logic [15:0] ra;
    logic [15:0] exp;
  } vec_t;
  vec_t tv[12];
  gpio_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();
  gpio_ctrl #(
    .WIDTH(8), .DATA_WIDTH(16), .ADDR_WIDTH(16), .BASE_ADDR(B), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst(rst), .io(bus), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic wr(logic [15:0] a, logic [15:0] d);
    @(negedge clk);
    bus.io_addr = a;
    bus.io_wdata = d;
    bus.io_wr = 1'b1;
    @(negedge clk);
    bus.io_wr = 1'b0;
  endtask
  task automatic rd(logic [15:0] a, logic [15:0] e, string name);
    sb_t s;
    @(negedge clk);
    bus.io_addr = a;
    bus.io_rd = 1'b1;
    sb.push_back('{name: name, exp: e});
    #2;
    s = sb.pop_front();
    chk(s.name, bus.io_rdata, s.exp);
    bus.io_rd = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, required finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.io_addr = '0;
    bus.io_wdata = '0;
    bus.io_wr = 1'b0;
    bus.io_rd = 1'b0;
    tv[0]  = '{1'b1, B + 16'd0, 16'h00A5, B + 16'd0, 16'h00A5};
    tv[1]  = '{1'b1, B + 16'd6, 16'h0102, B + 16'd0, 16'h00A7};
    tv[2]  = '{1'b1, B + 16'd7, 16'h0004, B + 16'd0, 16'h00A3};
    tv[3]  = '{1'b1, B + 16'd1, 16'hFFFF, B + 16'd1, 16'h00FF};
    tv[4]  = '{1'b1, B + 16'd3, 16'h1234, B + 16'd3, 16'h0034};
    tv[5]  = '{1'b1, B + 16'd4, 16'h00F0, B + 16'd4, 16'h00F0};
    tv[6]  = '{1'b0, B,         16'h0000, B + 16'd6, 16'h0000};
    tv[7]  = '{1'b0, B,         16'h0000, B + 16'd7, 16'h0000};
    tv[8]  = '{1'b1, B + 16'd2, 16'h00FF, B + 16'd2, 16'h0000};
    tv[9]  = '{1'b0, B,         16'h0000, B + 16'd8, 16'h0000};
    tv[10] = '{1'b1, B + 16'd8, 16'h0055, B + 16'd0, 16'h00A3};
    tv[11] = '{1'b1, B + 16'd5, 16'h00FF, B + 16'd5, 16'h0000};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_gpio_oe", gpio_oe, 0);
    chk("rst_irq", irq, 0);
    rd(B, 16'h0000, "rst_out_rd");
    for (int i = 0; i < 12; i++) begin
      if (tv[i].do_wr) wr(tv[i].wa, tv[i].wd);
      rd(tv[i].ra, tv[i].exp, $sformatf("vec%0d", i));
    end
    chk("vec_gpio_out", gpio_out, 16'h00A3);
    chk("vec_gpio_oe", gpio_oe, 16'h00FF);
    wr(B + 16'd4, 16'h0000);
`ifdef GPIO_DEBOUNCE_EN
    wr(B + 16'd3, 16'h0001);
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[0] = 1'b0;
    for (int i = 0; i < 8; i++) rd(B + 16'd2, 16'h0000, "db_pulse_in");
    rd(B + 16'd5, 16'h0000, "db_pulse_event");
    @(negedge clk);
    gpio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    rd(B + 16'd2, 16'h0000, "db_level_in_early");
    rd(B + 16'd2, 16'h0001, "db_level_in");
    repeat (3) @(negedge clk);
    rd(B + 16'd5, 16'h0001, "db_level_event");
    gpio_in[0] = 1'b0;
`else
    wr(B + 16'd3, 16'h0008);
    @(negedge clk);
    gpio_in[3] = 1'b1;
    rd(B + 16'd2, 16'h0000, "in_after_k");
    rd(B + 16'd2, 16'h0008, "in_after_k1");
    chk("irq_before_k2", irq, 0);
    rd(B + 16'd5, 16'h0008, "event_rise");
    chk("irq_rise", irq, 1);
    wr(B + 16'd5, 16'h0008);
    rd(B + 16'd5, 16'h0000, "event_w1c");
    chk("irq_w1c", irq, 0);
    @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    rd(B + 16'd5, 16'h0000, "no_fall_event");
    @(negedge clk);
    gpio_in[3] = 1'b1;
    @(negedge clk);
    wr(B + 16'd5, 16'h0008);
    rd(B + 16'd5, 16'h0008, "event_w1c_collide");
    chk("irq_collide", irq, 1);
    wr(B + 16'd5, 16'h0008);
    rd(B + 16'd5, 16'h0000, "event_w1c_late");
    chk("irq_w1c_late", irq, 0);
    wr(B + 16'd4, 16'h0008);
    @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (3) @(negedge clk);
    rd(B + 16'd5, 16'h0008, "event_fall");
    chk("irq_fall", irq, 1);
`endif
    @(negedge clk);
    gpio_in = 8'h5A;
    bus.io_addr = B;
    bus.io_wdata = 16'h00FF;
    bus.io_wr = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("midrst_gpio_out", gpio_out, 0);
    chk("midrst_gpio_oe", gpio_oe, 0);
    chk("midrst_irq", irq, 0);
    @(negedge clk);
    bus.io_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (DB + 6) @(negedge clk);
    for (int o = 0; o < 8; o++)
      rd(B + 16'(o), (o == 2) ? 16'h005A : 16'h0000, $sformatf("postrst_off%0d", o));
    chk("postrst_irq", irq, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
